// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared state type, select-width helper and counter width for stream_demux
package stream_demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: advance on inc unless already saturated
    always_comb begin
        count_d = (inc && (count_q != '1)) ? count_q + 1'b1 : count_q;
    end

    // count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: one-deep registered demux routing beats to one of N_CH channels; STREAM_DEMUX_STATS_EN adds drop_cnt
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [DATA_W-1:0]     out_data
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [SEL_W:0]  N_CH_L = N_CH[SEL_W:0];
    localparam logic [N_CH-1:0] ONE    = {{(N_CH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sel_ok;
    logic                in_xfer;
    logic                out_xfer;
    logic                drop_inc;

    // handshake decode, next state and outputs; an invalid select is swallowed without loading the stage
    always_comb begin
        sel_ok    = {1'b0, in_sel} < N_CH_L;
        out_xfer  = (state_q == FULL) && out_ready[sel_q];
        in_ready  = (state_q == EMPTY) || out_ready[sel_q];
        in_xfer   = in_valid && in_ready;
        drop_inc  = in_xfer && !sel_ok;
        state_d   = (in_xfer && sel_ok) ? FULL : (out_xfer ? EMPTY : state_q);
        sel_d     = (in_xfer && sel_ok) ? in_sel : sel_q;
        data_d    = (in_xfer && sel_ok) ? in_data : data_q;
        out_valid = (state_q == FULL) ? ONE << sel_q : '0;
        out_data  = data_q;
    end

    // holding stage; reset drops any held beat at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_cnt)
    );
`else
    logic unused_drop;
    assign unused_drop = drop_inc;
`endif

endmodule
